ir_fetch: RTL

IR_FETCH -- requirements
Module: ir_fetch

---
 rtl/ir_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ir_fetch.sv
// Two-read instruction fetch: gathers a 16-bit instruction from byte-wide memory
// (high byte at pc, low byte at pc+1). The instruction word updates in one step.
module ir_fetch #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] pc,
  input  logic [7:0]    mem_data,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   instr,
  output logic [2:0]    opcode,
  output logic [AW-1:0] ir_addr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HI  = 3'd1,
    CAP_HI = 3'd2,
    RD_LO  = 3'd3,
    CAP_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          load_pc_s;
  logic [AW-1:0] pc_r;
  logic [7:0]    hi_r;
  logic [15:0]   instr_r;
  logic          mem_rd_r;
  logic [AW-1:0] mem_addr_r;
  logic          busy_r;
  logic          done_r;

  // Low-byte address; the adder width gives the modulo-2^AW wrap for free.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return a + {{(AW-1){1'b0}}, 1'b1};
  endfunction

  // Next-state decode; start only matters where a new fetch may begin
  always_comb begin
    state_s   = state_r;
    load_pc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = RD_HI;
          load_pc_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      RD_HI:  state_s = CAP_HI;
      CAP_HI: state_s = RD_LO;
      RD_LO:  state_s = CAP_LO;
      CAP_LO: state_s = DONE;
      DONE: begin
        if (start) begin
          state_s   = RD_HI;
          load_pc_s = 1'b1;
        end else begin
          state_s   = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {AW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      mem_rd_r <= (state_s == RD_HI) || (state_s == RD_LO);
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == DONE);
      // RD_HI is only ever entered together with a pc load, so use pc directly
      if (state_s == RD_HI) begin
        mem_addr_r <= pc;
      end else if (state_s == RD_LO) begin
        mem_addr_r <= addr_inc(pc_r);
      end
    end
  end

  // Fetch datapath: latched pc, high byte, and the assembled instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= {AW{1'b0}};
      hi_r    <= 8'h00;
      instr_r <= 16'h0000;
    end else begin
      if (load_pc_s) begin
        pc_r <= pc;
      end
      if (state_r == CAP_HI) begin
        hi_r <= mem_data;
      end
      if (state_r == CAP_LO) begin
        instr_r <= {hi_r, mem_data};
      end
    end
  end

  assign mem_rd   = mem_rd_r;
  assign mem_addr = mem_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign instr    = instr_r;
  assign opcode   = instr_r[15:13];
  assign ir_addr  = instr_r[AW-1:0];

endmodule
